// File: rtl/sys_ctrl_pkg.sv
// Shared definitions for the burst-capable system controller: command codes,
// FSM state encoding, operand addresses and the command decoder.
package sys_ctrl_pkg;

    // UART command codes (first frame of every command)
    localparam logic [7:0] CMD_RF_WR    = 8'hAA;
    localparam logic [7:0] CMD_RF_RD    = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP   = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP  = 8'hDD;
    localparam logic [7:0] CMD_BURST_RD = 8'hEE;
    localparam logic [7:0] CMD_BURST_WR = 8'hFF;

    // RF locations that receive the ALU operands
    localparam int RF_OP1_ADDR = 0;
    localparam int RF_OP2_ADDR = 1;

    typedef enum logic [2:0] {
        OP_RF_WR,
        OP_RF_RD,
        OP_ALU,
        OP_ALU_NOP,
        OP_BURST_RD,
        OP_BURST_WR
    } op_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WAIT_ADDR,
        ST_WAIT_LEN,
        ST_WAIT_DATA,
        ST_WAIT_OP1,
        ST_WAIT_OP2,
        ST_WAIT_FUN,
        ST_WRITE,
        ST_WRITE_OP1,
        ST_WRITE_OP2,
        ST_READ,
        ST_PUSH_RD,
        ST_ALU,
        ST_PUSH_LO,
        ST_PUSH_HI
    } state_t;

    typedef struct packed {
        logic known;
        op_t  op;
    } dec_t;

    // Map a command byte onto an operation; known=0 for anything unrecognised
    function automatic dec_t decode_cmd(input logic [7:0] code);
        dec_t d;
        d.known = 1'b1;
        d.op    = OP_RF_WR;
        case (code)
            CMD_RF_WR:    d.op = OP_RF_WR;
            CMD_RF_RD:    d.op = OP_RF_RD;
            CMD_ALU_OP:   d.op = OP_ALU;
            CMD_ALU_NOP:  d.op = OP_ALU_NOP;
            CMD_BURST_RD: d.op = OP_BURST_RD;
            CMD_BURST_WR: d.op = OP_BURST_WR;
            default:      d.known = 1'b0;
        endcase
        return d;
    endfunction

    // States in which the controller is waiting for a UART frame
    function automatic logic is_wait(input state_t s);
        return (s == ST_WAIT_ADDR) || (s == ST_WAIT_LEN) || (s == ST_WAIT_DATA) ||
               (s == ST_WAIT_OP1)  || (s == ST_WAIT_OP2) || (s == ST_WAIT_FUN);
    endfunction

endpackage

// File: rtl/sys_ctrl_timeout.sv
// Inter-frame timeout counter. Cleared by clr, counts while en is high and
// saturates at TIMEOUT-1, where expired is asserted.
module sys_ctrl_timeout #(
    parameter int TIMEOUT = 1024
) (
    input  logic i_CLK,
    input  logic i_RST,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] count_q;

    assign expired = (count_q == CW'(TIMEOUT - 1));

    // Count cycles spent waiting; clear has priority over counting
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (en && !expired) begin
            count_q <= count_q + 1'b1;
        end
    end

endmodule

// File: rtl/sys_ctrl_burst.sv
// Command controller between the UART RX path, register file, ALU and TX FIFO.
// Decodes command frames and sequences single/burst RF accesses and ALU runs,
// with inter-frame timeout and command error reporting.
module sys_ctrl_burst
    import sys_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int ALU_FUN_WIDTH = 4,
    parameter int LEN_WIDTH     = 4,
    parameter int TIMEOUT       = 1024
) (
    input  logic                    i_CLK,
    input  logic                    i_RST,
    input  logic [DATA_WIDTH-1:0]   i_RX_P_DATA,
    input  logic                    i_RX_D_VLD,
    input  logic [2*DATA_WIDTH-1:0] i_ALU_OUT,
    input  logic                    i_OUT_Valid,
    input  logic [DATA_WIDTH-1:0]   i_RdData,
    input  logic                    i_RdData_Valid,
    input  logic                    i_FIFO_FULL,
    output logic [ADDR_WIDTH-1:0]   o_Address,
    output logic [DATA_WIDTH-1:0]   o_WrData,
    output logic                    o_WrEn,
    output logic                    o_RdEn,
    output logic [ALU_FUN_WIDTH-1:0] o_ALU_FUN,
    output logic                    o_ALU_EN,
    output logic                    o_CLK_EN,
    output logic [DATA_WIDTH-1:0]   o_FIFO_DATA,
    output logic                    o_WR_INC,
    output logic                    o_Cmd_Err,
    output logic                    o_Busy
);

    state_t                     state_q, state_d;
    op_t                        op_q;
    dec_t                       dec;
    logic [ADDR_WIDTH-1:0]      addr_q;
    logic [DATA_WIDTH-1:0]      data_q;
    logic [LEN_WIDTH-1:0]       cnt_q;
    logic [ALU_FUN_WIDTH-1:0]   fun_q;
    logic [2*DATA_WIDTH-1:0]    alu_q;
    logic                       err_q, err_d;
    logic                       to_clr, to_en, to_expired;
    logic [LEN_WIDTH-1:0]       len_in;
    logic                       last_beat;

    assign dec       = decode_cmd(i_RX_P_DATA[7:0]);
    assign len_in    = i_RX_P_DATA[LEN_WIDTH-1:0];
    assign last_beat = (cnt_q == LEN_WIDTH'(1));
    assign o_Busy    = (state_q != ST_IDLE);
    assign o_Cmd_Err = err_q;

    // Restart the timeout on entry to every wait state and on each accepted frame
    assign to_en  = is_wait(state_q);
    assign to_clr = !is_wait(state_q) || i_RX_D_VLD;

    sys_ctrl_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .i_CLK   (i_CLK),
        .i_RST   (i_RST),
        .clr     (to_clr),
        .en      (to_en),
        .expired (to_expired)
    );

    // State and error-pulse register
    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            state_q <= ST_IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    // Next-state decode and strobe generation
    // NOTE: every output of this block is defaulted first so no path leaves a latch behind.
    always_comb begin
        state_d     = state_q;
        err_d       = 1'b0;
        o_Address   = addr_q;
        o_WrData    = data_q;
        o_WrEn      = 1'b0;
        o_RdEn      = 1'b0;
        o_ALU_FUN   = '0;
        o_ALU_EN    = 1'b0;
        o_CLK_EN    = 1'b0;
        o_FIFO_DATA = '0;
        o_WR_INC    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_RX_D_VLD) begin
                    if (dec.known) begin
                        case (dec.op)
                            OP_ALU:     state_d = ST_WAIT_OP1;
                            OP_ALU_NOP: state_d = ST_WAIT_FUN;
                            default:    state_d = ST_WAIT_ADDR;
                        endcase
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_WAIT_ADDR: begin
                if (i_RX_D_VLD) begin
                    case (op_q)
                        OP_RF_WR: state_d = ST_WAIT_DATA;
                        OP_RF_RD: state_d = ST_READ;
                        default:  state_d = ST_WAIT_LEN;
                    endcase
                end
            end
            ST_WAIT_LEN: begin
                if (i_RX_D_VLD) begin
                    if (len_in == '0) begin
                        state_d = ST_IDLE;
                        err_d   = 1'b1;
                    end else if (op_q == OP_BURST_RD) begin
                        state_d = ST_READ;
                    end else begin
                        state_d = ST_WAIT_DATA;
                    end
                end
            end
            ST_WAIT_DATA: if (i_RX_D_VLD) state_d = ST_WRITE;
            ST_WAIT_OP1:  if (i_RX_D_VLD) state_d = ST_WRITE_OP1;
            ST_WAIT_OP2:  if (i_RX_D_VLD) state_d = ST_WRITE_OP2;
            ST_WAIT_FUN:  if (i_RX_D_VLD) state_d = ST_ALU;
            ST_WRITE: begin
                o_WrEn = 1'b1;
                if (op_q == OP_BURST_WR && !last_beat) state_d = ST_WAIT_DATA;
                else                                   state_d = ST_IDLE;
            end
            ST_WRITE_OP1: begin
                o_WrEn    = 1'b1;
                o_Address = ADDR_WIDTH'(RF_OP1_ADDR);
                state_d   = ST_WAIT_OP2;
            end
            ST_WRITE_OP2: begin
                o_WrEn    = 1'b1;
                o_Address = ADDR_WIDTH'(RF_OP2_ADDR);
                state_d   = ST_WAIT_FUN;
            end
            ST_READ: begin
                o_RdEn = 1'b1;
                if (i_RdData_Valid) state_d = ST_PUSH_RD;
            end
            ST_PUSH_RD: begin
                o_WR_INC    = ~i_FIFO_FULL;
                o_FIFO_DATA = data_q;
                if (!i_FIFO_FULL) begin
                    if (op_q == OP_BURST_RD && !last_beat) state_d = ST_READ;
                    else                                   state_d = ST_IDLE;
                end
            end
            ST_ALU: begin
                o_ALU_EN  = 1'b1;
                o_CLK_EN  = 1'b1;
                o_ALU_FUN = fun_q;
                if (i_OUT_Valid) state_d = ST_PUSH_LO;
            end
            ST_PUSH_LO: begin
                o_WR_INC    = ~i_FIFO_FULL;
                o_FIFO_DATA = alu_q[DATA_WIDTH-1:0];
                if (!i_FIFO_FULL) state_d = ST_PUSH_HI;
            end
            ST_PUSH_HI: begin
                o_WR_INC    = ~i_FIFO_FULL;
                o_FIFO_DATA = alu_q[2*DATA_WIDTH-1:DATA_WIDTH];
                if (!i_FIFO_FULL) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A frame arriving on the expiry cycle wins over the timeout
        if (is_wait(state_q) && !i_RX_D_VLD && to_expired) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
        end
    end

    // Frame, read-data and ALU-result capture plus burst address/count stepping
    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            op_q   <= OP_RF_WR;
            addr_q <= '0;
            data_q <= '0;
            cnt_q  <= '0;
            fun_q  <= '0;
            alu_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_RX_D_VLD && dec.known) op_q <= dec.op;
                end
                ST_WAIT_ADDR: begin
                    if (i_RX_D_VLD) addr_q <= i_RX_P_DATA[ADDR_WIDTH-1:0];
                end
                ST_WAIT_LEN: begin
                    if (i_RX_D_VLD) cnt_q <= len_in;
                end
                ST_WAIT_DATA, ST_WAIT_OP1, ST_WAIT_OP2: begin
                    if (i_RX_D_VLD) data_q <= i_RX_P_DATA;
                end
                ST_WAIT_FUN: begin
                    if (i_RX_D_VLD) fun_q <= i_RX_P_DATA[ALU_FUN_WIDTH-1:0];
                end
                ST_WRITE: begin
                    if (op_q == OP_BURST_WR) begin
                        addr_q <= addr_q + 1'b1;
                        cnt_q  <= cnt_q - 1'b1;
                    end
                end
                ST_READ: begin
                    if (i_RdData_Valid) data_q <= i_RdData;
                end
                ST_PUSH_RD: begin
                    if (!i_FIFO_FULL && op_q == OP_BURST_RD) begin
                        addr_q <= addr_q + 1'b1;
                        cnt_q  <= cnt_q - 1'b1;
                    end
                end
                ST_ALU: begin
                    if (i_OUT_Valid) alu_q <= i_ALU_OUT;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sys_ctrl_burst.sv
// Self-checking bench for sys_ctrl_burst: directed command scenarios followed
// by randomized command streams, compared against a command-level model.
module tb_sys_ctrl_burst;

    localparam int TIMEOUT = 1024;

    logic        i_CLK = 1'b0;
    logic        i_RST;
    logic [7:0]  i_RX_P_DATA;
    logic        i_RX_D_VLD;
    logic [15:0] i_ALU_OUT;
    logic        i_OUT_Valid;
    logic [7:0]  i_RdData;
    logic        i_RdData_Valid;
    logic        i_FIFO_FULL;
    logic [3:0]  o_Address;
    logic [7:0]  o_WrData;
    logic        o_WrEn;
    logic        o_RdEn;
    logic [3:0]  o_ALU_FUN;
    logic        o_ALU_EN;
    logic        o_CLK_EN;
    logic [7:0]  o_FIFO_DATA;
    logic        o_WR_INC;
    logic        o_Cmd_Err;
    logic        o_Busy;

    sys_ctrl_burst #(
        .DATA_WIDTH(8), .ADDR_WIDTH(4), .ALU_FUN_WIDTH(4), .LEN_WIDTH(4), .TIMEOUT(TIMEOUT)
    ) dut (
        .i_CLK(i_CLK), .i_RST(i_RST),
        .i_RX_P_DATA(i_RX_P_DATA), .i_RX_D_VLD(i_RX_D_VLD),
        .i_ALU_OUT(i_ALU_OUT), .i_OUT_Valid(i_OUT_Valid),
        .i_RdData(i_RdData), .i_RdData_Valid(i_RdData_Valid),
        .i_FIFO_FULL(i_FIFO_FULL),
        .o_Address(o_Address), .o_WrData(o_WrData), .o_WrEn(o_WrEn), .o_RdEn(o_RdEn),
        .o_ALU_FUN(o_ALU_FUN), .o_ALU_EN(o_ALU_EN), .o_CLK_EN(o_CLK_EN),
        .o_FIFO_DATA(o_FIFO_DATA), .o_WR_INC(o_WR_INC),
        .o_Cmd_Err(o_Cmd_Err), .o_Busy(o_Busy)
    );

    always #5 i_CLK = ~i_CLK;

    int total = 0;
    int bad   = 0;

    // Environment: register file contents as seen by the RF responder
    logic [7:0]  rf_env [16];
    // Model: register file contents implied by the commands issued
    logic [7:0]  model_rf [16];

    logic [11:0] obs_wr[$], exp_wr[$];
    logic [7:0]  obs_push[$], exp_push[$];
    int          obs_err = 0, exp_err = 0;
    int          obs_rden = 0, exp_rden = 0;
    int          inc_full = 0;

    int          rd_lat = 1, alu_lat = 1;
    int          rd_cnt = 0, alu_cnt = 0;
    logic [15:0] alu_val = '0;
    logic [3:0]  exp_fun = '0;
    logic        full_rand = 1'b0;
    logic [7:0]  bw_data[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge i_CLK);
            #1;
        end
    endtask

    // Output monitor: samples on the falling edge
    initial begin
        forever begin
            @(negedge i_CLK);
            if (i_RST) begin
                if (o_WrEn) begin
                    obs_wr.push_back({o_Address, o_WrData});
                    rf_env[o_Address] = o_WrData;
                end
                if (o_WR_INC) obs_push.push_back(o_FIFO_DATA);
                if (o_WR_INC && i_FIFO_FULL) inc_full++;
                if (o_Cmd_Err) obs_err++;
                if (o_RdEn) obs_rden++;
            end
        end
    end

    // RF read responder: valid on the rd_lat-th cycle of a held read request
    initial begin
        forever begin
            @(posedge i_CLK);
            #2;
            if (o_RdEn) begin
                rd_cnt++;
                if (rd_cnt == rd_lat) begin
                    i_RdData_Valid = 1'b1;
                    i_RdData       = rf_env[o_Address];
                end else begin
                    i_RdData_Valid = 1'b0;
                end
            end else begin
                rd_cnt         = 0;
                i_RdData_Valid = 1'b0;
            end
        end
    end

    // ALU responder: result valid on the alu_lat-th enabled cycle
    initial begin
        forever begin
            @(posedge i_CLK);
            #2;
            if (o_ALU_EN) begin
                alu_cnt++;
                if (alu_cnt == alu_lat) begin
                    i_OUT_Valid = 1'b1;
                    i_ALU_OUT   = alu_val;
                    check("alu_fun", o_ALU_FUN, exp_fun);
                    check("clk_en", o_CLK_EN, 1);
                end else begin
                    i_OUT_Valid = 1'b0;
                end
            end else begin
                alu_cnt     = 0;
                i_OUT_Valid = 1'b0;
            end
        end
    end

    // Random TX FIFO back-pressure
    initial begin
        forever begin
            @(posedge i_CLK);
            #1;
            if (full_rand) i_FIFO_FULL = ($urandom_range(0, 3) == 0);
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [7:0] b, input int gap);
        i_RX_P_DATA = b;
        i_RX_D_VLD  = 1'b1;
        tick(1);
        i_RX_D_VLD  = 1'b0;
        tick(gap);
    endtask

    task automatic send_r(input logic [7:0] b);
        send(b, $urandom_range(1, 3));
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (o_Busy && n < 5000) begin
            tick(1);
            n++;
        end
        check({tag, "_idle_wait"}, (n < 5000), 1);
    endtask

    // Wait for the command to finish and compare everything it did against the model
    task automatic finish_cmd(input string tag);
        int nw, np;
        wait_idle(tag);
        tick(2);
        check({tag, "_busy"}, o_Busy, 0);
        check({tag, "_nwr"}, obs_wr.size(), exp_wr.size());
        nw = (obs_wr.size() < exp_wr.size()) ? obs_wr.size() : exp_wr.size();
        for (int i = 0; i < nw; i++) check({tag, "_wr"}, obs_wr[i], exp_wr[i]);
        check({tag, "_npush"}, obs_push.size(), exp_push.size());
        np = (obs_push.size() < exp_push.size()) ? obs_push.size() : exp_push.size();
        for (int i = 0; i < np; i++) check({tag, "_push"}, obs_push[i], exp_push[i]);
        check({tag, "_err"}, obs_err, exp_err);
        check({tag, "_rden"}, obs_rden, exp_rden);
        obs_wr.delete(); exp_wr.delete();
        obs_push.delete(); exp_push.delete();
        obs_err = 0; exp_err = 0;
        obs_rden = 0; exp_rden = 0;
    endtask

    task automatic cmd_write(input logic [7:0] a, input logic [7:0] d);
        exp_wr.push_back({a[3:0], d});
        model_rf[a[3:0]] = d;
        send_r(8'hAA); send_r(a); send_r(d);
    endtask

    task automatic cmd_read(input logic [7:0] a, input int lat);
        rd_lat = lat;
        exp_push.push_back(model_rf[a[3:0]]);
        exp_rden += lat;
        send_r(8'hBB); send_r(a);
    endtask

    task automatic cmd_alu(input logic [7:0] op1, input logic [7:0] op2, input logic [7:0] fun,
                           input logic [15:0] val, input int lat);
        alu_lat = lat; alu_val = val; exp_fun = fun[3:0];
        exp_wr.push_back({4'h0, op1});
        exp_wr.push_back({4'h1, op2});
        model_rf[0] = op1;
        model_rf[1] = op2;
        exp_push.push_back(val[7:0]);
        exp_push.push_back(val[15:8]);
        send_r(8'hCC); send_r(op1); send_r(op2); send_r(fun);
    endtask

    task automatic cmd_alu_nop(input logic [7:0] fun, input logic [15:0] val, input int lat);
        alu_lat = lat; alu_val = val; exp_fun = fun[3:0];
        exp_push.push_back(val[7:0]);
        exp_push.push_back(val[15:8]);
        send_r(8'hDD); send_r(fun);
    endtask

    task automatic cmd_bread(input logic [7:0] a, input logic [7:0] lb, input int lat);
        logic [3:0] ad;
        rd_lat = lat;
        for (int i = 0; i < int'(lb[3:0]); i++) begin
            ad = a[3:0] + 4'(i);
            exp_push.push_back(model_rf[ad]);
        end
        exp_rden += int'(lb[3:0]) * lat;
        send_r(8'hEE); send_r(a); send_r(lb);
    endtask

    // Burst write of the bytes queued in bw_data (length frame = lb)
    task automatic cmd_bwrite(input logic [7:0] a, input logic [7:0] lb);
        logic [3:0] ad;
        for (int i = 0; i < int'(lb[3:0]); i++) begin
            ad = a[3:0] + 4'(i);
            exp_wr.push_back({ad, bw_data[i]});
            model_rf[ad] = bw_data[i];
        end
        send_r(8'hFF); send_r(a); send_r(lb);
        for (int i = 0; i < int'(lb[3:0]); i++) send_r(bw_data[i]);
    endtask

    initial begin
        logic [7:0] b, a, lb;
        int         n, kind;

        i_RST = 1'b0;
        i_RX_P_DATA = '0; i_RX_D_VLD = 1'b0;
        i_ALU_OUT = '0; i_OUT_Valid = 1'b0;
        i_RdData = '0; i_RdData_Valid = 1'b0;
        i_FIFO_FULL = 1'b0;
        for (int i = 0; i < 16; i++) begin
            rf_env[i]   = 8'($urandom);
            model_rf[i] = rf_env[i];
        end

        tick(3);
        check("rst_busy", o_Busy, 0);
        check("rst_wren", o_WrEn, 0);
        check("rst_rden", o_RdEn, 0);
        check("rst_wrinc", o_WR_INC, 0);
        check("rst_err", o_Cmd_Err, 0);
        check("rst_aluen", o_ALU_EN, 0);
        check("rst_addr", o_Address, 0);
        check("rst_wrdata", o_WrData, 0);
        i_RST = 1'b1;
        tick(2);

        // Single write, read-back with a 3-cycle read latency
        cmd_write(8'h05, 8'h3C); finish_cmd("aa");
        cmd_write(8'h07, 8'hA5); finish_cmd("aa2");
        cmd_read(8'h07, 3);      finish_cmd("bb");

        // ALU with operands: RF[0]=10, RF[1]=20, result 0030
        cmd_alu(8'h10, 8'h20, 8'h00, 16'h0030, 2); finish_cmd("cc");

        // Burst write across the address wrap
        bw_data.delete();
        bw_data.push_back(8'h11); bw_data.push_back(8'h22); bw_data.push_back(8'h33);
        cmd_bwrite(8'h0E, 8'h03); finish_cmd("ff");
        check("ff_rf_e", model_rf[14], 8'h11);
        check("ff_rf_0", model_rf[0], 8'h33);

        // Burst read of 2 with the FIFO full for 5 cycles at the first push
        full_rand   = 1'b0;
        i_FIFO_FULL = 1'b1;
        rd_lat      = 2;
        exp_push.push_back(model_rf[2]);
        exp_push.push_back(model_rf[3]);
        exp_rden += 4;
        send_r(8'hEE); send_r(8'h02); send(8'h02, 0);
        n = 0;
        while (!i_RdData_Valid && n < 100) begin
            tick(1);
            n++;
        end
        check("ee_rdvld_seen", (n < 100), 1);
        check("ee_inc_held", o_WR_INC, 0);
        tick(5);
        i_FIFO_FULL = 1'b0;
        finish_cmd("ee");

        // Timeout while waiting for the write data frame
        exp_err = 1;
        send_r(8'hAA); send(8'h05, 1);
        tick(TIMEOUT - 8);
        check("to_still_busy", o_Busy, 1);
        finish_cmd("timeout");

        // Unknown command code
        exp_err = 1;
        send(8'h12, 2);
        finish_cmd("unknown");

        // Zero-length burst write
        exp_err = 1;
        send_r(8'hFF); send_r(8'h00); send_r(8'h00);
        finish_cmd("zero_len");

        // Reset in the middle of a command
        send_r(8'hAA); send(8'h03, 1);
        i_RST = 1'b0;
        #1;
        check("rst_mid_busy", o_Busy, 0);
        check("rst_mid_wren", o_WrEn, 0);
        check("rst_mid_err", o_Cmd_Err, 0);
        tick(2);
        i_RST = 1'b1;
        tick(1);
        finish_cmd("rst_mid");

        // Randomized command stream with random FIFO back-pressure
        full_rand = 1'b1;
        for (int k = 0; k < 40; k++) begin
            kind = $urandom_range(0, 7);
            a    = 8'($urandom);
            case (kind)
                0: cmd_write(a, 8'($urandom));
                1: cmd_read(a, $urandom_range(1, 4));
                2: cmd_alu(8'($urandom), 8'($urandom), 8'($urandom),
                           16'($urandom), $urandom_range(1, 4));
                3: cmd_alu_nop(8'($urandom), 16'($urandom), $urandom_range(1, 4));
                4: begin
                    lb = {4'($urandom), 4'($urandom_range(1, 15))};
                    cmd_bread(a, lb, $urandom_range(1, 4));
                end
                5: begin
                    lb = {4'($urandom), 4'($urandom_range(1, 15))};
                    bw_data.delete();
                    for (int i = 0; i < int'(lb[3:0]); i++) bw_data.push_back(8'($urandom));
                    cmd_bwrite(a, lb);
                end
                6: begin
                    do b = 8'($urandom);
                    while (b inside {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF});
                    exp_err = 1;
                    send_r(b);
                end
                default: begin
                    exp_err = 1;
                    send_r(($urandom_range(0, 1) == 0) ? 8'hEE : 8'hFF);
                    send_r(a);
                    send_r({4'($urandom), 4'h0});
                end
            endcase
            finish_cmd("rand");
        end
        full_rand   = 1'b0;
        i_FIFO_FULL = 1'b0;

        check("no_push_while_full", inc_full, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sys_ctrl_burst.md
Name: sys_ctrl_burst

Overview:
Command controller between the RX synchroniser, register file, ALU and TX FIFO. It decodes UART command frames and sequences RF writes and reads, ALU operations, and RF burst transfers.
- Parametrised successor to the single-access system controller. Adds burst read/write, inter-byte timeout, unknown-command error reporting and FIFO-full-gated writes.
- Sits in the reference clock domain. Replaces the existing controller at the same position in the design.

Parameters:
DATA_WIDTH, 8, frame/RF data width
ADDR_WIDTH, 4, RF address width (address taken from i_RX_P_DATA[ADDR_WIDTH-1:0])
ALU_FUN_WIDTH, 4, ALU function code width
LEN_WIDTH, 4, burst length field width; legal length 1..2^LEN_WIDTH-1
TIMEOUT, 1024, cycles allowed between frames of one command

Ports:
i_CLK  in  1  system clock
i_RST  in  1  asynchronous active-low reset
i_RX_P_DATA  in  DATA_WIDTH  received frame
i_RX_D_VLD  in  1  one-cycle strobe per received frame
i_ALU_OUT  in  2*DATA_WIDTH  ALU result
i_OUT_Valid  in  1  ALU result valid
i_RdData  in  DATA_WIDTH  RF read data
i_RdData_Valid  in  1  RF read data valid
i_FIFO_FULL  in  1  TX FIFO full
o_Address  out  ADDR_WIDTH  RF address
o_WrData  out  DATA_WIDTH  RF write data
o_WrEn  out  1  RF write strobe
o_RdEn  out  1  RF read request
o_ALU_FUN  out  ALU_FUN_WIDTH  ALU function
o_ALU_EN  out  1  ALU enable
o_CLK_EN  out  1  ALU clock-gate enable
o_FIFO_DATA  out  DATA_WIDTH  TX FIFO write data
o_WR_INC  out  1  TX FIFO write strobe
o_Cmd_Err  out  1  one-cycle pulse on bad command, zero length or timeout
o_Busy  out  1  high in every state except IDLE

Behaviour:
- Reset: state IDLE. Address, data, length and timeout registers are 0. All strobes are 0, o_Busy = 0.
- Command codes:
  - AA: RF write. Frames: addr, data.
  - BB: RF read. Frames: addr.
  - CC: ALU with operands. Frames: op1 -> RF[0], op2 -> RF[1], fun.
  - DD: ALU without operands. Frames: fun.
  - EE: burst read. Frames: addr, len.
  - FF: burst write. Frames: addr, len, then len data frames.
- IDLE:
  - i_RX_D_VLD with a known code enters the first frame-wait state.
  - Any other code: pulse o_Cmd_Err, stay in IDLE.
- Frame-wait states: on i_RX_D_VLD, latch the frame and advance.
  - Frames arrive at least 2 cycles apart.
  - An i_RX_D_VLD in any non-wait state other than IDLE is ignored.
- Timeout:
  - The counter clears on entry to each wait state and counts while waiting.
  - Reaching TIMEOUT-1 goes to IDLE with an o_Cmd_Err pulse. No partial write is issued for an unreceived frame.
  - A frame arriving on the same cycle as the timeout takes priority and is accepted.
- Length: len = i_RX_P_DATA[LEN_WIDTH-1:0]. len = 0 gives o_Cmd_Err and IDLE.
- Write state: o_WrEn is high for exactly one cycle, with o_Address and o_WrData stable in that cycle.
  - Burst write writes latched data to addr, then increments addr modulo 2^ADDR_WIDTH, decrements the remaining count and returns to the data-wait state.
  - Count reaching 0 goes to IDLE.
- Read state: o_RdEn is held until i_RdData_Valid; the data is latched on that cycle.
- FIFO state: o_WR_INC = ~i_FIFO_FULL, and the state advances only when o_WR_INC is 1. Exactly one push per byte.
  - Burst read loops read -> FIFO push -> next address until the count is exhausted.
- ALU:
  - o_ALU_EN and o_CLK_EN are held until i_OUT_Valid, then the result is latched.
  - Pushes the low byte then the high byte to the FIFO.
  - o_ALU_FUN is held from the fun latch until the result is latched.
- Reset mid-operation aborts immediately to IDLE with no strobe in the reset cycle.
- o_Address mux sources: constant 0, constant 1, the latched/incrementing address register.

Decomposition:
- Package sys_ctrl_pkg holds:
  - command code constants;
  - state enumeration (one-hot not required);
  - RF operand address constants (0, 1).
- Sub-module sys_ctrl_timeout: counter with clear/enable inputs and expired output, parametrised by TIMEOUT.

Test Plan:
- AA,05,3C -> one o_WrEn cycle with o_Address=5 and o_WrData=3C; o_Busy low afterwards.
- BB,07 with RdData=A5 after a 3-cycle latency -> o_RdEn held 3 cycles, then one o_WR_INC with o_FIFO_DATA=A5.
- CC,10,20,00 with ALU_OUT=0030 -> writes RF[0]=10 and RF[1]=20, then FIFO pushes 30 then 00.
- FF,0E,3,11,22,33 -> writes RF[E]=11, RF[F]=22, RF[0]=33 (address wrap).
- EE,02,2 with i_FIFO_FULL high for 5 cycles at the first push -> o_WR_INC low while full, then exactly 2 pushes in order.
- Error cases, each -> one o_Cmd_Err pulse and return to IDLE:
  - AA,05 then silence for TIMEOUT cycles -> no o_WrEn;
  - code 12;
  - FF,00,0 (zero length).
